output_port: RTL

- Transmit end of the router-to-router link; counterpart of the input port at the downstream router.
- Accepts flits from the crossbar after switch allocation and buffers them in a FIFO.
- Drives them onto the link one per cycle, gated by the downstream on/off flow-control signal.
- Enforces wormhole packet framing on the link and reports buffer status back to the switch allocator.

---
 rtl/output_port.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/output_port.sv
// Router output port: flit FIFO, on/off gated link driver and wormhole
// framing checker with occupancy and sticky error reporting.
package noc_params;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t       flit_label;
    logic [DATA_W-1:0] data;
  } flit_t;
endpackage

module output_port
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  flit_t                        xb_flit_i,
  input  logic                         xb_valid_i,
  input  logic                         on_off_i,
  output flit_t                        data_o,
  output logic                         valid_flit_o,
  output logic                         is_full_o,
  output logic                         is_empty_o,
  output logic                         in_packet_o,
  output logic [$clog2(BUFFER_SIZE):0] flit_count_o,
  output logic                         error_o
);

  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_SIZE);

  typedef enum logic {
    IDLE   = 1'b0,
    PACKET = 1'b1
  } state_t;

  flit_t          mem_q [BUFFER_SIZE];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  state_t         state_q, state_d;
  flit_t          data_q, data_d;
  logic           valid_q, valid_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           err_q, err_d;
  logic           push, pop, send;
  flit_t          front;

  always_comb begin
    push     = xb_valid_i && !full_q;
    pop      = !empty_q && on_off_i;
    front    = mem_q[rd_ptr_q];
    send     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    // A write into a full FIFO is lost even if a pop frees a slot.
    err_d    = err_q | (xb_valid_i & full_q);

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      unique case (state_q)
        IDLE: begin
          unique case (front.flit_label)
            HEAD: begin
              send    = 1'b1;
              state_d = PACKET;
            end
            HEADTAIL: send = 1'b1;
            default:  err_d = 1'b1;
          endcase
        end
        PACKET: begin
          unique case (front.flit_label)
            BODY: send = 1'b1;
            TAIL: begin
              send    = 1'b1;
              state_d = IDLE;
            end
            default: err_d = 1'b1;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end

    if (send) begin
      valid_d = 1'b1;
      data_d  = front;
    end

    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= xb_flit_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      err_q    <= err_d;
    end
  end

  assign data_o       = data_q;
  assign valid_flit_o = valid_q;
  assign is_full_o    = full_q;
  assign is_empty_o   = empty_q;
  assign in_packet_o  = (state_q == PACKET);
  assign flit_count_o = count_q;
  assign error_o      = err_q;

endmodule
